// File: rtl/gb_host_seq_if.sv
// Command/response stream plus single-beat ghostbus port of the host sequencer.
// master = the sequencer; slave = host command source together with the bus responder.
interface gb_host_seq_if #(
  parameter int AW   = 24,
  parameter int DW   = 32,
  parameter int TO_W = 16
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_data;
  logic [DW-1:0]   cmd_mask;
  logic [TO_W-1:0] cmd_timeout;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_status;

  logic [AW-1:0]   gb_addr;
  logic [DW-1:0]   gb_wdata;
  logic            gb_wen;
  logic            gb_rstb;
  logic [DW-1:0]   gb_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_timeout,
    input  rsp_ready, gb_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
    output gb_addr, gb_wdata, gb_wen, gb_rstb
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_timeout,
    output rsp_ready, gb_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
    input  gb_addr, gb_wdata, gb_wen, gb_rstb
  );
endinterface

// File: rtl/gb_host_seq.sv
// Ghostbus initiator: one command in, single-beat write/read/poll/rmw on the bus, one response out.
// Strobes and handshakes decode from the state register, so an async reset drops them at once.
module gb_host_seq #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int TO_W       = 16
) (
  input  logic         gb_clk,
  input  logic         gb_rst,
  gb_host_seq_if.master bus,
  output logic         busy
);

  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LATENCY);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_RMW   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [2:0] {
    IDLE, WRITE, RD_ISSUE, RD_WAIT, EVAL, RMW_WR, RESP
  } state_t;

  state_t state, state_d;

  logic [1:0]      op_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   mask_q;
  logic [TO_W-1:0] to_q;
  logic [TO_W-1:0] attempts;
  logic [LW-1:0]   lat_cnt;
  logic [DW-1:0]   rd_q;
  logic [DW-1:0]   wr_q;
  logic            poll_hit;
  logic            poll_out;
  logic            lat_done;

  assign wr_q     = (rd_q & ~mask_q) | (data_q & mask_q);
  assign poll_hit = ((rd_q ^ data_q) & mask_q) == '0;
  assign poll_out = (attempts == to_q);
  assign lat_done = (lat_cnt == LW'(1));

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d       = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.gb_wen    = 1'b0;
    bus.gb_rstb   = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (bus.cmd_valid)
          state_d = (bus.cmd_op == OP_WRITE) ? WRITE : RD_ISSUE;
      end
      WRITE: begin
        bus.gb_wen = 1'b1;
        state_d    = RESP;
      end
      RD_ISSUE: begin
        bus.gb_rstb = 1'b1;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done) state_d = EVAL;
      end
      EVAL: begin
        case (op_q)
          OP_POLL: state_d = (poll_hit || poll_out) ? RESP : RD_ISSUE;
          OP_RMW:  state_d = RMW_WR;
          default: state_d = RESP;
        endcase
      end
      RMW_WR: begin
        bus.gb_wen = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields are settled before RESP is entered and left alone while in RESP.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      op_q           <= OP_WRITE;
      data_q         <= '0;
      mask_q         <= '0;
      to_q           <= '0;
      attempts       <= '0;
      lat_cnt        <= '0;
      rd_q           <= '0;
      bus.gb_addr    <= '0;
      bus.gb_wdata   <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            data_q      <= bus.cmd_data;
            mask_q      <= bus.cmd_mask;
            to_q        <= bus.cmd_timeout;
            attempts    <= '0;
            bus.gb_addr <= bus.cmd_addr;
            if (bus.cmd_op == OP_WRITE) bus.gb_wdata <= bus.cmd_data;
          end
        end
        WRITE: begin
          bus.rsp_data   <= data_q;
          bus.rsp_status <= ST_OK;
        end
        RD_ISSUE: lat_cnt <= LAT_INIT;
        RD_WAIT: begin
          // Responder decodes gb_addr combinationally, so gb_addr is untouched here.
          if (lat_done) rd_q    <= bus.gb_rdata;
          else          lat_cnt <= lat_cnt - LW'(1);
        end
        EVAL: begin
          case (op_q)
            OP_READ: begin
              bus.rsp_data   <= rd_q;
              bus.rsp_status <= ST_OK;
            end
            OP_POLL: begin
              if (poll_hit) begin
                bus.rsp_data   <= rd_q;
                bus.rsp_status <= ST_OK;
              end else if (poll_out) begin
                bus.rsp_data   <= rd_q;
                bus.rsp_status <= ST_TIMEOUT;
              end else begin
                attempts <= attempts + TO_W'(1);
              end
            end
            OP_RMW:  bus.gb_wdata <= wr_q;
            default: ;
          endcase
        end
        RMW_WR: begin
          bus.rsp_data   <= bus.gb_wdata;
          bus.rsp_status <= ST_OK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_host_seq.sv
// Directed bench for gb_host_seq: scripted responder, bus monitor, hand-computed expectations.
module tb_gb_host_seq;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int TO_W = 16;

  logic gb_clk = 1'b0;
  logic gb_rst = 1'b1;
  logic busy;

  gb_host_seq_if #(.AW(AW), .DW(DW), .TO_W(TO_W)) bus ();

  gb_host_seq #(.AW(AW), .DW(DW), .RD_LATENCY(1), .TO_W(TO_W)) dut (
    .gb_clk (gb_clk),
    .gb_rst (gb_rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 gb_clk = ~gb_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder: each read strobe pops the next scripted value, visible one cycle later.
  logic [DW-1:0] rq[$];
  always @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst)
      bus.gb_rdata <= '0;
    else if (bus.gb_rstb && rq.size() > 0)
      bus.gb_rdata <= rq.pop_front();
  end

  int            rstb_cnt = 0;
  int            wen_cnt = 0;
  int            both_hi = 0;
  int            addr_moved = 0;
  int            vld_cnt = 0;
  logic          prev_rstb = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [AW-1:0] wen_addr = '0;
  logic [DW-1:0] wen_data = '0;
  always @(negedge gb_clk) begin
    if (bus.gb_rstb) rstb_cnt++;
    if (bus.gb_wen) begin
      wen_cnt++;
      wen_addr = bus.gb_addr;
      wen_data = bus.gb_wdata;
    end
    if (bus.gb_wen && bus.gb_rstb) both_hi++;
    if (prev_rstb && bus.gb_addr != prev_addr) addr_moved++;
    if (bus.rsp_valid) vld_cnt++;
    prev_rstb = bus.gb_rstb;
    prev_addr = bus.gb_addr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m, input logic [TO_W-1:0] to);
    int n = 0;
    bus.cmd_op      = op;
    bus.cmd_addr    = a;
    bus.cmd_data    = d;
    bus.cmd_mask    = m;
    bus.cmd_timeout = to;
    bus.cmd_valid   = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge gb_clk);
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(posedge gb_clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [DW-1:0] d, output logic [1:0] st);
    lat = 0;
    do begin
      @(negedge gb_clk);
      lat++;
    end while (!bus.rsp_valid && lat < 200);
    chk("rsp_wait", 64'(bus.rsp_valid), 64'd1);
    d  = bus.rsp_data;
    st = bus.rsp_status;
  endtask

  task automatic finish_rsp();
    @(posedge gb_clk);
    @(negedge gb_clk);
  endtask

  initial begin
    int            lat;
    int            r0, w0, v0;
    logic [DW-1:0] d;
    logic [1:0]    st;

    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_addr    = '0;
    bus.cmd_data    = '0;
    bus.cmd_mask    = '0;
    bus.cmd_timeout = '0;
    bus.rsp_ready   = 1'b1;

    @(negedge gb_clk);
    @(negedge gb_clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    chk("rst_gb_addr", 64'(bus.gb_addr), 64'd0);
    chk("rst_gb_wdata", 64'(bus.gb_wdata), 64'd0);
    chk("rst_gb_wen", 64'(bus.gb_wen), 64'd0);
    chk("rst_gb_rstb", 64'(bus.gb_rstb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    gb_rst = 1'b0;
    @(negedge gb_clk);

    // write 0x000001 <- 0x0E
    r0 = rstb_cnt; w0 = wen_cnt;
    send(2'b00, 24'h000001, 32'h0000000E, 32'h0, 16'd0);
    wait_rsp(lat, d, st);
    chk("wr_latency", 64'(lat), 64'd2);
    chk("wr_status", 64'(st), 64'd0);
    chk("wr_rsp_data", 64'(d), 64'h0E);
    chk("wr_wen_pulses", 64'(wen_cnt - w0), 64'd1);
    chk("wr_addr", 64'(wen_addr), 64'h000001);
    chk("wr_wdata", 64'(wen_data), 64'h0E);
    chk("wr_rstb_pulses", 64'(rstb_cnt - r0), 64'd0);
    finish_rsp();

    // read 0x000000 -> 0x42
    rq.push_back(32'h42);
    r0 = rstb_cnt; w0 = wen_cnt;
    send(2'b01, 24'h000000, 32'h0, 32'h0, 16'd0);
    wait_rsp(lat, d, st);
    chk("rd_latency", 64'(lat), 64'd4);
    chk("rd_rsp_data", 64'(d), 64'h42);
    chk("rd_status", 64'(st), 64'd0);
    chk("rd_rstb_pulses", 64'(rstb_cnt - r0), 64'd1);
    chk("rd_wen_pulses", 64'(wen_cnt - w0), 64'd0);
    finish_rsp();

    // poll hits on the third read
    rq.push_back(32'hC); rq.push_back(32'hC); rq.push_back(32'h3);
    r0 = rstb_cnt;
    send(2'b10, 24'h000004, 32'h3, 32'hF, 16'd5);
    wait_rsp(lat, d, st);
    chk("poll_reads", 64'(rstb_cnt - r0), 64'd3);
    chk("poll_status", 64'(st), 64'd0);
    chk("poll_rsp_data", 64'(d), 64'h3);
    finish_rsp();

    // poll never matches, timeout 2 -> 3 reads
    rq.push_back(32'h5); rq.push_back(32'h6); rq.push_back(32'h7);
    r0 = rstb_cnt;
    send(2'b10, 24'h000004, 32'h3, 32'hF, 16'd2);
    wait_rsp(lat, d, st);
    chk("to_reads", 64'(rstb_cnt - r0), 64'd3);
    chk("to_status", 64'(st), 64'd1);
    chk("to_rsp_data", 64'(d), 64'h7);
    finish_rsp();

    // rmw 0x20: 0x25 with mask 0xF0, data 0xA0 -> 0xA5
    rq.push_back(32'h25);
    r0 = rstb_cnt; w0 = wen_cnt;
    send(2'b11, 24'h000020, 32'hA0, 32'hF0, 16'd0);
    wait_rsp(lat, d, st);
    chk("rmw_latency", 64'(lat), 64'd5);
    chk("rmw_rstb_pulses", 64'(rstb_cnt - r0), 64'd1);
    chk("rmw_wen_pulses", 64'(wen_cnt - w0), 64'd1);
    chk("rmw_wr_addr", 64'(wen_addr), 64'h000020);
    chk("rmw_wdata", 64'(wen_data), 64'hA5);
    chk("rmw_rsp_data", 64'(d), 64'hA5);
    chk("rmw_status", 64'(st), 64'd0);
    finish_rsp();

    // response backpressure: hold rsp_ready low for 4 cycles
    bus.rsp_ready = 1'b0;
    send(2'b00, 24'h000010, 32'h00001234, 32'h0, 16'd0);
    wait_rsp(lat, d, st);
    for (int i = 0; i < 4; i++) begin
      @(negedge gb_clk);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(bus.rsp_data), 64'h1234);
      chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    finish_rsp();
    chk("bp_released", 64'(bus.cmd_ready), 64'd1);

    // reset in the middle of a read
    rq.push_back(32'h99);
    send(2'b01, 24'h000008, 32'h0, 32'h0, 16'd0);
    @(negedge gb_clk);
    chk("mid_rstb_issue", 64'(bus.gb_rstb), 64'd1);
    @(negedge gb_clk);
    chk("mid_busy", 64'(busy), 64'd1);
    v0 = vld_cnt;
    gb_rst = 1'b1;
    #1;
    chk("mid_rst_rstb", 64'(bus.gb_rstb), 64'd0);
    chk("mid_rst_wen", 64'(bus.gb_wen), 64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mid_rst_gb_addr", 64'(bus.gb_addr), 64'd0);
    @(negedge gb_clk);
    @(negedge gb_clk);
    gb_rst = 1'b0;
    repeat (6) @(negedge gb_clk);
    chk("mid_no_rsp", 64'(vld_cnt - v0), 64'd0);
    chk("mid_idle", 64'(bus.cmd_ready), 64'd1);

    chk("no_wen_rstb_overlap", 64'(both_hi), 64'd0);
    chk("rd_addr_stable", 64'(addr_moved), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
